// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'b00,
    LIGHT_GREEN  = 2'b01,
    LIGHT_YELLOW = 2'b10,
    LIGHT_RED    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    S_OFF,
    S_GREEN,
    S_YELLOW,
    S_RED,
    S_BLINK_ON,
    S_BLINK_OFF
  } state_t;

  localparam int DEF_T_GREEN     = 8;
  localparam int DEF_T_GREEN_MIN = 3;
  localparam int DEF_T_YELLOW    = 2;
  localparam int DEF_T_RED       = 6;
  localparam int DEF_T_BLINK     = 2;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic light_t lamp(input state_t s);
    case (s)
      S_GREEN:    return LIGHT_GREEN;
      S_YELLOW:   return LIGHT_YELLOW;
      S_RED:      return LIGHT_RED;
      S_BLINK_ON: return LIGHT_YELLOW;
      default:    return LIGHT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down-counter that parks at zero; times each controller phase.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// Traffic light controller: timed green/yellow/red cycle with pedestrian
// cut-short and a blinking alert override.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN     = DEF_T_GREEN,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_RED       = DEF_T_RED,
  parameter int T_BLINK     = DEF_T_BLINK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       alert,
  input  logic       ped_req,
  output logic [1:0] light,
  output logic       walk,
  output logic       ped_pending
);

  localparam int CNT_W  = $clog2(max4(T_GREEN, T_YELLOW, T_RED, T_BLINK)) + 1;
  // Timer value at which T_GREEN_MIN green cycles have been spent.
  localparam int CUT_AT = T_GREEN - T_GREEN_MIN;

  if (T_GREEN < 1 || T_YELLOW < 1 || T_RED < 1 || T_BLINK < 1 ||
      T_GREEN_MIN >= T_GREEN) begin : g_param_check
    $error("traffic_ctrl: invalid duration parameters");
  end

  state_t           state_d, state_q;
  logic [1:0]       light_d, light_q;
  logic             walk_d, walk_q;
  logic             ped_d, ped_q;
  logic             ped_in;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      S_GREEN:                return CNT_W'(T_GREEN - 1);
      S_YELLOW:               return CNT_W'(T_YELLOW - 1);
      S_RED:                  return CNT_W'(T_RED - 1);
      S_BLINK_ON, S_BLINK_OFF: return CNT_W'(T_BLINK - 1);
      default:                return '0;
    endcase
  endfunction

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    ped_in  = ped_req && (state_q inside {S_GREEN, S_YELLOW, S_RED});

    if (alert) begin
      case (state_q)
        S_BLINK_ON:  state_d = tmr_zero ? S_BLINK_OFF : S_BLINK_ON;
        S_BLINK_OFF: state_d = tmr_zero ? S_BLINK_ON : S_BLINK_OFF;
        default:     state_d = S_BLINK_ON;
      endcase
    end else begin
      case (state_q)
        S_OFF:    if (en) state_d = S_GREEN;
        // A request arriving this cycle counts, so the cut lands on the same edge that latches it.
        S_GREEN:  if (tmr_zero || ((ped_q || ped_in) && tmr_value <= CNT_W'(CUT_AT)))
                    state_d = S_YELLOW;
        S_YELLOW: if (tmr_zero) state_d = S_RED;
        S_RED:    if (tmr_zero) state_d = S_GREEN;
        S_BLINK_ON, S_BLINK_OFF: state_d = S_RED;
        default:  state_d = S_OFF;
      endcase
    end

    ped_d = ped_q | ped_in;
    if ((state_q == S_RED && state_d != S_RED) ||
        (state_d inside {S_OFF, S_BLINK_ON, S_BLINK_OFF})) begin
      ped_d = 1'b0;
    end

    // Walk is decided once, on entry to red from the normal cycle, then held.
    walk_d = 1'b0;
    if (state_d == S_RED) begin
      walk_d = (state_q == S_RED) ? walk_q : ((state_q == S_YELLOW) && ped_d);
    end

    light_d  = lamp(state_d);
    tmr_load = (state_d != state_q);
    tmr_val  = dur_m1(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      light_q <= LIGHT_OFF;
      walk_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
      walk_q  <= walk_d;
      ped_q   <= ped_d;
    end
  end

  assign light       = light_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed scoreboard bench for traffic_ctrl with default timing.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       alert = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] light;
  logic       walk;
  logic       ped_pending;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  traffic_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .alert       (alert),
    .ped_req     (ped_req),
    .light       (light),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic expect_n(input logic [1:0] l, input logic w, input logic p, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({l, w, p});
  endtask

  task automatic check(input string tag);
    logic [3:0] o;
    logic [3:0] e;
    o = {light, walk, ped_pending};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, got light/walk/pend=%b", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: got light/walk/pend=%b want %b", tag, o, e);
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic run(input string tag);
    while (exp_q.size() > 0) cyc(tag);
  endtask

  task automatic do_reset(input string tag);
    en = 1'b0; alert = 1'b0; ped_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_n(2'b00, 1'b0, 1'b0, 1);
    check(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #12;
    // Plain cycle
    do_reset("reset");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 8);
    expect_n(2'b10, 1'b0, 1'b0, 2);
    expect_n(2'b11, 1'b0, 1'b0, 6);
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("normal");
    en = 1'b0;

    // Early pedestrian request: green trimmed to T_GREEN_MIN
    do_reset("reset2");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("ped1_g1");
    en = 1'b0; ped_req = 1'b1;
    expect_n(2'b01, 1'b0, 1'b1, 1);
    cyc("ped1_g2");
    ped_req = 1'b0;
    expect_n(2'b01, 1'b0, 1'b1, 1);
    expect_n(2'b10, 1'b0, 1'b1, 2);
    expect_n(2'b11, 1'b1, 1'b1, 6);
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("ped1_seq");

    // Late pedestrian request cuts green at cycle 6
    do_reset("reset3");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 6);
    run("ped6_green");
    en = 1'b0; ped_req = 1'b1;
    expect_n(2'b10, 1'b0, 1'b1, 1);
    cyc("ped6_cut");
    ped_req = 1'b0;
    expect_n(2'b10, 1'b0, 1'b1, 1);
    expect_n(2'b11, 1'b1, 1'b1, 6);
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("ped6_seq");

    // Alert during red, with a simultaneous pedestrian press
    do_reset("reset4");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 8);
    expect_n(2'b10, 1'b0, 1'b0, 2);
    expect_n(2'b11, 1'b0, 1'b0, 1);
    run("alert_pre");
    en = 1'b0; alert = 1'b1; ped_req = 1'b1;
    expect_n(2'b10, 1'b0, 1'b0, 1);
    cyc("alert_entry");
    ped_req = 1'b0;
    expect_n(2'b10, 1'b0, 1'b0, 1);
    expect_n(2'b00, 1'b0, 1'b0, 2);
    expect_n(2'b10, 1'b0, 1'b0, 2);
    run("blink");
    alert = 1'b0;
    expect_n(2'b11, 1'b0, 1'b0, 6);
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("alert_exit");

    // Asynchronous reset in the middle of yellow
    do_reset("reset5");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 8);
    expect_n(2'b10, 1'b0, 1'b0, 1);
    run("pre_rst");
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_n(2'b00, 1'b0, 1'b0, 1);
    check("rst_mid_yellow");
    @(negedge clk);
    rst = 1'b0; ped_req = 1'b1;
    expect_n(2'b00, 1'b0, 1'b0, 1);
    cyc("off_ped_ignored");
    ped_req = 1'b0;
    expect_n(2'b00, 1'b0, 1'b0, 2);
    run("off_hold");
    en = 1'b1;
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("restart");
    en = 1'b0;

    // Alert beats en in OFF; pedestrian ignored while blinking
    do_reset("reset6");
    en = 1'b1; alert = 1'b1;
    expect_n(2'b10, 1'b0, 1'b0, 1);
    cyc("off_alert");
    ped_req = 1'b1;
    expect_n(2'b10, 1'b0, 1'b0, 1);
    cyc("blink_ped");
    ped_req = 1'b0;
    expect_n(2'b00, 1'b0, 1'b0, 1);
    cyc("blink_off");
    alert = 1'b0;
    expect_n(2'b11, 1'b0, 1'b0, 6);
    expect_n(2'b01, 1'b0, 1'b0, 1);
    run("blink_exit");
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter T_GREEN, default 8: green phase length in clock cycles.
REQ-002 Parameter T_GREEN_MIN, default 3: minimum green cycles before a pedestrian request may cut green short.
REQ-003 Parameter T_YELLOW, default 2: yellow phase length in cycles.
REQ-004 Parameter T_RED, default 6: red phase length in cycles.
REQ-005 Parameter T_BLINK, default 2: cycles per half-period of the alert blink.
REQ-006 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port en, input, 1: start request; sampled only in OFF.
REQ-009 Port alert, input, 1: alert mode request; level-sensitive.
REQ-010 Port ped_req, input, 1: pedestrian button; a single-cycle pulse is sufficient.
REQ-011 Port light, output, 2: lamp code 00 off, 01 green, 10 yellow, 11 red; registered.
REQ-012 Port walk, output, 1: pedestrian walk lamp; registered.
REQ-013 Port ped_pending, output, 1: latched pedestrian request not yet served.

Function
REQ-014 States SHALL be OFF, GREEN, YELLOW, RED, BLINK_ON and BLINK_OFF; light SHALL be 00/01/10/11 in OFF/GREEN/YELLOW/RED, 10 in BLINK_ON and 00 in BLINK_OFF.
REQ-015 A down-counter SHALL load (duration-1) on every state entry; a state SHALL be left on the cycle after the counter reads 0, giving exactly the programmed duration.
REQ-016 OFF -> GREEN on the first edge with en=1 and alert=0; otherwise OFF holds.
REQ-017 Normal cycle: GREEN (T_GREEN) -> YELLOW (T_YELLOW) -> RED (T_RED) -> GREEN, repeating indefinitely.
REQ-018 ped_req=1 in GREEN, YELLOW or RED SHALL set ped_pending on the next edge; ped_req in OFF, BLINK_ON or BLINK_OFF SHALL be ignored.
REQ-019 In GREEN with ped_pending=1 and at least T_GREEN_MIN green cycles elapsed, the next edge SHALL enter YELLOW.
REQ-020 walk SHALL be 1 exactly while in RED with ped_pending set on RED entry; ped_pending SHALL clear on RED exit.
REQ-021 alert=1 in any state SHALL enter BLINK_ON on the next edge, overriding timers, en and ped_pending.
REQ-022 BLINK_ON and BLINK_OFF SHALL alternate every T_BLINK cycles while alert=1.
REQ-023 alert falling while blinking SHALL enter RED with a full T_RED load; ped_pending SHALL be 0 and walk 0 on that entry.
REQ-024 Simultaneous events SHALL be resolved in the priority order rst > alert > counter expiry or pedestrian cut > hold.
REQ-025 The counter width SHALL be $clog2 of the largest duration parameter plus 1 bit; every duration SHALL be at least 1, and T_GREEN_MIN SHALL be less than T_GREEN.

Reset
REQ-026 rst=1 SHALL immediately force the state to OFF, light to 00, walk to 0, ped_pending to 0 and the counter to 0, including mid-phase.
REQ-027 After rst falls, the first transition SHALL be OFF -> GREEN on the first edge with en=1 and alert=0.

Structure
REQ-028 Package traffic_pkg SHALL hold the light_t lamp-code enum, the state_t enum and the default duration constants.
REQ-029 Sub-module phase_timer SHALL be a loadable down-counter with load, value and zero outputs, instantiated once.

Verification
REQ-030 rst, then en pulse -> light 01 for 8 cycles, 10 for 2 cycles, 11 for 6 cycles, then 01; walk stays 0 throughout.
REQ-031 ped_req pulse at green cycle 1 -> ped_pending=1; YELLOW entered after green cycle 3; RED held 6 cycles with walk=1; ped_pending=0 after RED.
REQ-032 ped_req at green cycle 6 -> green ends at cycle 6; yellow follows immediately.
REQ-033 alert=1 during RED -> light sequence 10,10,00,00,10,... while alert=1; alert=0 -> light 11 for 6 cycles with walk=0.
REQ-034 rst asserted mid-YELLOW between clock edges -> light 00 without waiting for an edge; remains OFF until en=1.
REQ-035 alert and en both 1 in OFF -> BLINK_ON, not GREEN; ped_req during blink -> ped_pending stays 0.
